approx_error_monitor: RTL and testbench
=======================================

APPROX_ERROR_MONITOR -- requirements
Module: approx_error_monitor

Interface
REQ-001 Parameter N, default 16, operand/sum width of the approximate adder under test.
REQ-002 Parameter CW, default 16, sample-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle pulse: begin a measurement run.
REQ-006 num_samples  input  CW  samples in the run; sampled only when start is accepted.
REQ-007 in_valid  input  1  op_a/op_b/approx_sum valid this cycle.
REQ-008 in_ready  output  1  monitor accepts a sample this cycle.
REQ-009 op_a, op_b  input  N each  operands fed to the approximate adder.
REQ-010 approx_sum  input  N  N-bit sum output of the approximate adder (no carry-out).
REQ-011 busy  output  1  run in progress.
REQ-012 done  output  1  one-cycle pulse: statistics final.
REQ-013 err_count  output  CW  samples with nonzero error distance.
REQ-014 sum_ed  output  N+1+CW  accumulated error distance.
REQ-015 max_ed  output  N+1  largest error distance in run.

Function
REQ-016 States IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-017 IDLE: start=1 -> latch num_samples, clear err_count/sum_ed/max_ed, clear accepted/retired counters, go RUN; start ignored in every other state.
REQ-018 Sample accepted on cycle with in_valid=1 and in_ready=1; in_ready=1 only in RUN while accepted count < latched num_samples, else 0.
REQ-019 Exact sum = op_a + op_b, N+1 bits (carry kept); approx zero-extended to N+1 bits.
REQ-020 ED = |exact - approx|, N+1 bits unsigned.
REQ-021 Pipeline: stage 1 registers operands/approx_sum on acceptance; stage 2 computes ED and updates statistics; a sample affects outputs 2 cycles after acceptance.
REQ-022 Per retired sample: sum_ed += ED; err_count += 1 if ED != 0; max_ed = max(max_ed, ED).
REQ-023 sum_ed and err_count cannot overflow at maximum num_samples by construction; no wrap or saturation logic.
REQ-024 RUN -> DRAIN when accepted count reaches num_samples; DRAIN -> DONE when retired count equals num_samples.
REQ-025 DONE lasts exactly one cycle with done=1, then IDLE.
REQ-026 busy=1 in RUN and DRAIN, 0 in IDLE and DONE.
REQ-027 num_samples=0: RUN -> DRAIN -> DONE with no acceptance; done pulses 3 cycles after start, statistics all zero.
REQ-028 Statistics hold their values in IDLE after done until next accepted start.
REQ-029 in_valid while in_ready=0 has no effect; inputs need not be held.
REQ-030 Back-to-back samples accepted every cycle; gaps in in_valid allowed.

Reset
REQ-031 rst_n=0 at a rising edge: state IDLE; in_ready, busy, done 0; err_count, sum_ed, max_ed, internal counters and pipeline valids 0.
REQ-032 Reset mid-run discards in-flight samples; no done pulse for aborted run.

Verification
REQ-033 N=16, num_samples=1, op_a=0xFFFF, op_b=0x0001, approx_sum=0x0000 -> ED=0x10000; done pulse; err_count=1, sum_ed=0x10000, max_ed=0x10000.
REQ-034 num_samples=3, samples (0x0003,0x0004,approx 0x0007),(0x00F0,0x000F,approx 0x00FE),(0x1000,0x1000,approx 0x2003) -> err_count=2, sum_ed=4, max_ed=3.
REQ-035 num_samples=0 -> done 3 cycles after start, in_ready never 1, all statistics 0.
REQ-036 num_samples=2, in_valid held high 5 cycles -> exactly 2 acceptances, in_ready falls after second; start pulsed during RUN ignored.
REQ-037 rst_n=0 for one cycle after 1 of 4 samples accepted -> all outputs 0, IDLE, no done; new start runs cleanly.
REQ-038 Random 1000-sample run vs reference model of exact/approx sums -> err_count, sum_ed, max_ed match exactly.

Source files
------------

// File: rtl/approx_error_monitor_if.sv
// Sample/handshake/statistics bundle between a stimulus source and the
// approximate-adder error monitor.
interface approx_error_monitor_if #(
    parameter int N  = 16,
    parameter int CW = 16
);
    logic              start;
    logic [CW-1:0]     num_samples;
    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      op_a;
    logic [N-1:0]      op_b;
    logic [N-1:0]      approx_sum;
    logic              busy;
    logic              done;
    logic [CW-1:0]     err_count;
    logic [N+CW:0]     sum_ed;
    logic [N:0]        max_ed;

    modport master (
        output start, num_samples, in_valid, op_a, op_b, approx_sum,
        input  in_ready, busy, done, err_count, sum_ed, max_ed
    );

    modport slave (
        input  start, num_samples, in_valid, op_a, op_b, approx_sum,
        output in_ready, busy, done, err_count, sum_ed, max_ed
    );
endinterface

// File: rtl/approx_error_monitor.sv
// Measures error distance of an N-bit approximate adder against the exact
// (N+1)-bit sum over a run of samples; two-stage pipeline, Moore control.
module approx_error_monitor #(
    parameter int N  = 16,
    parameter int CW = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    approx_error_monitor_if.slave   bus
);
    localparam int EW = N + 1;
    localparam int SW = N + 1 + CW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_reg, state_next;

    logic [CW-1:0]   num_reg;
    logic [CW-1:0]   acc_cnt_reg;
    logic [CW-1:0]   ret_cnt_reg;

    logic            s1_valid_reg;
    logic [N-1:0]    s1_a_reg;
    logic [N-1:0]    s1_b_reg;
    logic [N-1:0]    s1_approx_reg;

    logic [CW-1:0]   err_count_reg;
    logic [SW-1:0]   sum_ed_reg;
    logic [EW-1:0]   max_ed_reg;

    logic            start_run;
    logic            in_ready_int;
    logic            accept;
    logic [EW-1:0]   exact_sum;
    logic [EW-1:0]   approx_ext;
    logic [EW-1:0]   ed;

    assign start_run    = (state_reg == IDLE) && bus.start;
    assign in_ready_int = (state_reg == RUN) && (acc_cnt_reg < num_reg);
    assign accept       = bus.in_valid && in_ready_int;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // RUN leaves only once every requested sample has been accepted; DRAIN
    // waits for the pipeline to retire them so the statistics are final at DONE.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (bus.start)                 state_next = RUN;
            RUN:     if (acc_cnt_reg == num_reg)    state_next = DRAIN;
            DRAIN:   if (ret_cnt_reg == num_reg)    state_next = DONE;
            DONE:                                   state_next = IDLE;
            default:                                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            num_reg     <= '0;
            acc_cnt_reg <= '0;
            ret_cnt_reg <= '0;
        end else if (start_run) begin
            num_reg     <= bus.num_samples;
            acc_cnt_reg <= '0;
            ret_cnt_reg <= '0;
        end else begin
            if (accept) begin
                acc_cnt_reg <= acc_cnt_reg + CW'(1);
            end
            if (s1_valid_reg) begin
                ret_cnt_reg <= ret_cnt_reg + CW'(1);
            end
        end
    end

    // Stage 1: capture the sample so callers need not hold inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_a_reg      <= '0;
            s1_b_reg      <= '0;
            s1_approx_reg <= '0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_a_reg      <= bus.op_a;
                s1_b_reg      <= bus.op_b;
                s1_approx_reg <= bus.approx_sum;
            end
        end
    end

    // Stage 2: error distance keeps the carry the approximate adder drops.
    assign exact_sum  = {1'b0, s1_a_reg} + {1'b0, s1_b_reg};
    assign approx_ext = {1'b0, s1_approx_reg};
    assign ed         = (exact_sum >= approx_ext) ? (exact_sum - approx_ext)
                                                  : (approx_ext - exact_sum);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count_reg <= '0;
            sum_ed_reg    <= '0;
            max_ed_reg    <= '0;
        end else if (start_run) begin
            err_count_reg <= '0;
            sum_ed_reg    <= '0;
            max_ed_reg    <= '0;
        end else if (s1_valid_reg) begin
            sum_ed_reg <= sum_ed_reg + SW'(ed);
            if (ed != '0) begin
                err_count_reg <= err_count_reg + CW'(1);
            end
            if (ed > max_ed_reg) begin
                max_ed_reg <= ed;
            end
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.busy      = (state_reg == RUN) || (state_reg == DRAIN);
    assign bus.done      = (state_reg == DONE);
    assign bus.err_count = err_count_reg;
    assign bus.sum_ed    = sum_ed_reg;
    assign bus.max_ed    = max_ed_reg;

endmodule

// File: tb/tb_approx_error_monitor.sv
// Scoreboard bench for approx_error_monitor: per-sample running statistics are
// queued on acceptance and compared when the sample retires two cycles later.
module tb_approx_error_monitor;
    localparam int N  = 16;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    approx_error_monitor_if #(.N(N), .CW(CW)) bus();

    approx_error_monitor #(.N(N), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        longint err;
        longint sum;
        longint max;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    longint mon_d;
    int     n_checks = 0;
    int     n_fail = 0;
    int     done_cnt = 0;
    int     acc_total = 0;
    longint m_err = 0;
    longint m_sum = 0;
    longint m_max = 0;
    logic [1:0] acc_pipe = 2'b00;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            acc_pipe = 2'b00;
        end else begin
            if (acc_pipe[1]) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ret_err", 64'(bus.err_count), mon_e.err);
                    check("ret_sum", 64'(bus.sum_ed), mon_e.sum);
                    check("ret_max", 64'(bus.max_ed), mon_e.max);
                end
            end
            acc_pipe = {acc_pipe[0], bus.in_valid & bus.in_ready};
            if (bus.in_valid && bus.in_ready) begin
                acc_total++;
                mon_d = longint'(bus.op_a) + longint'(bus.op_b) - longint'(bus.approx_sum);
                if (mon_d < 0) mon_d = -mon_d;
                if (mon_d != 0) m_err++;
                m_sum += mon_d;
                if (mon_d > m_max) m_max = mon_d;
                mon_e.err = m_err;
                mon_e.sum = m_sum;
                mon_e.max = m_max;
                exp_q.push_back(mon_e);
            end
            if (bus.done) begin
                done_cnt++;
                check("done_err", 64'(bus.err_count), m_err);
                check("done_sum", 64'(bus.sum_ed), m_sum);
                check("done_max", 64'(bus.max_ed), m_max);
                check("done_sb_empty", 64'(exp_q.size()), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int num);
        bus.start = 1'b1;
        bus.num_samples = CW'(num);
        m_err = 0;
        m_sum = 0;
        m_max = 0;
        tick();
        bus.start = 1'b0;
        bus.num_samples = 16'hFFFF;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] s);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.op_a = a;
        bus.op_b = b;
        bus.approx_sum = s;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            else tick();
        end
        if (!ok) check("send_timeout", 64'd0, 64'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.op_a = 16'($urandom_range(0, 65535));
        bus.op_b = 16'($urandom_range(0, 65535));
        bus.approx_sum = 16'($urandom_range(0, 65535));
    endtask

    task automatic wait_done(input int limit, output int cycles);
        bit seen = 1'b0;
        cycles = 0;
        for (int k = 0; k < limit && !seen; k++) begin
            @(negedge clk);
            cycles++;
            if (bus.done) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
        tick();
    endtask

    task automatic expect_stats(input string tag, input longint e_err, input longint e_sum, input longint e_max);
        check({tag, "_err"}, 64'(bus.err_count), e_err);
        check({tag, "_sum"}, 64'(bus.sum_ed), e_sum);
        check({tag, "_max"}, 64'(bus.max_ed), e_max);
    endtask

    task automatic expect_idle_zero(input string tag);
        check({tag, "_ready"}, 64'(bus.in_ready), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
        expect_stats(tag, 0, 0, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int a0;
        int d0;
        logic [15:0] ra, rb, rs;
        logic [16:0] rex;

        bus.start = 1'b0;
        bus.num_samples = '0;
        bus.in_valid = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        bus.approx_sum = '0;
        rst_n = 1'b0;
        repeat (3) tick();
        expect_idle_zero("reset");
        rst_n = 1'b1;
        tick();

        // Carry-out dropped by the approximate adder
        start_run(1);
        send(16'hFFFF, 16'h0001, 16'h0000);
        wait_done(20, cyc);
        expect_stats("carry", 1, 64'h10000, 64'h10000);
        repeat (3) tick();
        expect_stats("hold", 1, 64'h10000, 64'h10000);
        $display("run carry: err=%0d sum=0x%0h max=0x%0h", bus.err_count, bus.sum_ed, bus.max_ed);

        // Three back-to-back samples
        start_run(3);
        send(16'h0003, 16'h0004, 16'h0007);
        send(16'h00F0, 16'h000F, 16'h00FE);
        send(16'h1000, 16'h1000, 16'h2003);
        wait_done(20, cyc);
        expect_stats("three", 2, 4, 3);
        $display("run three: err=%0d sum=%0d max=%0d", bus.err_count, bus.sum_ed, bus.max_ed);

        // in_valid held 5 cycles against num_samples=2, start pulsed mid-run
        a0 = acc_total;
        d0 = done_cnt;
        start_run(2);
        check("run_busy", 64'(bus.busy), 64'd1);
        bus.in_valid = 1'b1;
        bus.op_a = 16'h0010;
        bus.op_b = 16'h0020;
        bus.approx_sum = 16'h0031;
        tick();
        bus.start = 1'b1;
        bus.num_samples = 16'd7;
        tick();
        bus.start = 1'b0;
        check("ready_fall", 64'(bus.in_ready), 64'd0);
        repeat (3) tick();
        bus.in_valid = 1'b0;
        check("hold_accepts", 64'(acc_total - a0), 64'd2);
        check("hold_done_once", 64'(done_cnt - d0), 64'd1);
        expect_stats("hold2", 2, 2, 1);
        $display("run hold: accepts=%0d err=%0d sum=%0d", acc_total - a0, bus.err_count, bus.sum_ed);

        // Empty run
        a0 = acc_total;
        start_run(0);
        wait_done(20, cyc);
        check("zero_latency", 64'(cyc), 64'd3);
        check("zero_accepts", 64'(acc_total - a0), 64'd0);
        expect_stats("zero", 0, 0, 0);
        $display("run zero: done after %0d cycles", cyc);

        // Reset mid-run
        start_run(4);
        send(16'h0001, 16'h0001, 16'h0000);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        expect_idle_zero("abort");
        d0 = done_cnt;
        repeat (6) tick();
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        start_run(2);
        send(16'h0005, 16'h0005, 16'h000A);
        send(16'h8000, 16'h8000, 16'h0000);
        wait_done(20, cyc);
        expect_stats("after_abort", 1, 64'h10000, 64'h10000);
        $display("run after abort: err=%0d sum=0x%0h", bus.err_count, bus.sum_ed);

        // Random 1000-sample run with gaps
        start_run(1000);
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            rex = {1'b0, ra} + {1'b0, rb};
            case ($urandom_range(0, 3))
                0:       rs = rex[15:0];
                1:       rs = rex[15:0] ^ 16'($urandom_range(0, 15));
                2:       rs = 16'($urandom_range(0, 65535));
                default: rs = rex[15:0] & 16'hFF00;
            endcase
            if ($urandom_range(0, 3) == 0) tick();
            send(ra, rb, rs);
        end
        wait_done(50, cyc);
        expect_stats("random", m_err, m_sum, m_max);
        $display("run random: err=%0d sum=%0d max=%0d", bus.err_count, bus.sum_ed, bus.max_ed);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
